// File: rtl/sd_pio_pkg.sv
// Shared constants and bus types for the SD bidirectional PIO.
package sd_pio_pkg;

  // Avalon word addresses of the register map
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  // Edge capture modes
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Decoded slave request for one cycle
  typedef struct packed {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
  } pio_req_t;

endpackage

// File: rtl/sd_pio_sync.sv
// WIDTH-wide, STAGES-deep input synchroniser, async reset to 0.
module sd_pio_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  // Shift the pin vector down the chain; chain[0] is the first capture flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sd_bidir_pio.sv
// WIDTH-pin bidirectional PIO with set/clear, edge capture and maskable irq.
module sd_bidir_pio
  import sd_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  inout  wire  [WIDTH-1:0]  bidir_port
);

  localparam int             CW       = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0]  WARM_MAX = CW'(SYNC_STAGES + 1);

  pio_req_t         req;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data_out, dir, irq_mask, edge_capture;
  logic [WIDTH-1:0] sync_in, prev, edges, cap_clr;
  logic [CW-1:0]    warm_cnt;
  logic             warm_done;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  assign req.wr    = chipselect & ~write_n;
  assign req.addr  = address;
  assign req.wdata = writedata;
  assign wd        = req.wdata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  // Per-pin tri-state driver
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
  end

  sd_pio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bidir_port),
    .q       (sync_in)
  );

  // One-cycle delayed copy of the synced pins for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= sync_in;
  end

  if (EDGE_TYPE == EDGE_RISE) begin : g_rise
    assign edges = sync_in & ~prev;
  end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
    assign edges = ~sync_in & prev;
  end else begin : g_any
    assign edges = sync_in ^ prev;
  end

  // Warm-up: hold off capture until the chain and prev hold real pin data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        warm_cnt <= '0;
    else if (!warm_done) warm_cnt <= warm_cnt + 1'b1;
  end

  assign warm_done = (warm_cnt == WARM_MAX);

  // Output data: plain load, atomic OR-set and AND-NOT-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_out <= RESET_OUT;
    else if (req.wr) begin
      case (req.addr)
        ADDR_DATA:   data_out <= wd;
        ADDR_OUTSET: data_out <= data_out | wd;
        ADDR_OUTCLR: data_out <= data_out & ~wd;
        default:     data_out <= data_out;
      endcase
    end
  end

  // Direction and interrupt mask registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir      <= '0;
      irq_mask <= '0;
    end else if (req.wr) begin
      if (req.addr == ADDR_DIR)     dir      <= wd;
      if (req.addr == ADDR_IRQMASK) irq_mask <= wd;
    end
  end

  assign cap_clr = (req.wr && req.addr == ADDR_EDGECAP) ? wd : '0;

  // Sticky edge capture, write-1-to-clear; a same-cycle edge wins over clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~cap_clr) | (edges & {WIDTH{warm_done}});
  end

  // Registered level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= |(edge_capture & irq_mask);
  end

  // Read mux; OUTSET/OUTCLR and unused addresses read 0
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = 32'(sync_in);
      ADDR_DIR:     rd_mux = 32'(dir);
      ADDR_IRQMASK: rd_mux = 32'(irq_mask);
      ADDR_EDGECAP: rd_mux = 32'(edge_capture);
      default:      rd_mux = '0;
    endcase
  end

  // Read data registered every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_sd_bidir_pio.sv
// Scoreboard bench: a pin-history model predicts reads and irq per cycle.
module tb_sd_bidir_pio;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int ET = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  wire  [W-1:0]  pins;

  logic [W-1:0]  ext_val = '1;
  logic          rd_tag = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference state, values after the most recent clock edge
  logic [W-1:0]  m_dout = '0, m_dir = '0, m_mask = '0, m_ec = '0;
  int            n_edges = 0;
  logic [W-1:0]  pin_q[$];
  logic [31:0]   rd_q[$];
  logic          irq_q[$];

  always #5 clk = ~clk;

  // External world drives every pin the DUT is not driving
  for (genvar i = 0; i < W; i++) begin : g_ext
    assign pins[i] = m_dir[i] ? 1'bz : ext_val[i];
  end

  sd_bidir_pio #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(ET), .RESET_OUT('0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .bidir_port (pins)
  );

  // Synced value seen after edge k: the pin value sampled S-1 edges earlier
  function automatic logic [W-1:0] sync_at(input int k);
    if (k < S) return '0;
    return pin_q[k-S];
  endfunction

  function automatic logic [W-1:0] edge_of(input logic [W-1:0] cur, input logic [W-1:0] old);
    case (ET)
      0:       return cur & ~old;
      1:       return ~cur & old;
      default: return cur ^ old;
    endcase
  endfunction

  // Reference model: advance one edge, queue the expected responses
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dout <= '0; m_dir <= '0; m_mask <= '0; m_ec <= '0;
      n_edges <= 0;
      pin_q.delete(); rd_q.delete(); irq_q.delete();
    end else begin
      automatic logic [W-1:0] d = writedata[W-1:0];
      automatic logic         we = chipselect & ~write_n;
      automatic logic [W-1:0] ev = '0;
      automatic logic [W-1:0] clr = '0;
      automatic logic [31:0]  rexp = '0;
      pin_q.push_back((m_dir & m_dout) | (~m_dir & ext_val));
      if (n_edges >= S + 1) ev = edge_of(sync_at(n_edges), sync_at(n_edges - 1));
      case (address)
        3'd0: rexp = 32'(sync_at(n_edges));
        3'd1: rexp = 32'(m_dir);
        3'd2: rexp = 32'(m_mask);
        3'd3: rexp = 32'(m_ec);
        default: rexp = '0;
      endcase
      if (rd_tag) rd_q.push_back(rexp);
      irq_q.push_back(|(m_ec & m_mask));
      if (we && address == 3'd3) clr = d;
      m_ec <= (m_ec & ~clr) | ev;
      if (we) begin
        case (address)
          3'd0: m_dout <= d;
          3'd1: m_dir  <= d;
          3'd2: m_mask <= d;
          3'd4: m_dout <= m_dout | d;
          3'd5: m_dout <= m_dout & ~d;
          default: ;
        endcase
      end
      n_edges <= n_edges + 1;
    end
  end

  // Monitor: compare registered outputs and pin levels mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      automatic logic [W-1:0] pexp = (m_dir & m_dout) | (~m_dir & ext_val);
      if (rd_q.size() > 0) begin
        automatic logic [31:0] e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
          errors++;
          $display("FAIL readdata t=%0t addr=%0d got=%h exp=%h", $time, address, readdata, e);
        end
      end
      if (irq_q.size() > 0) begin
        automatic logic e = irq_q.pop_front();
        checks++;
        if (irq !== e) begin
          errors++;
          $display("FAIL irq t=%0t got=%b exp=%b", $time, irq, e);
        end
      end
      checks++;
      if (pins !== pexp) begin
        errors++;
        $display("FAIL pins t=%0t got=%b exp=%b", $time, pins, pexp);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    chipselect = 1'b1; address = a; rd_tag = 1'b1;
    tick();
    chipselect = 1'b0; rd_tag = 1'b0;
  endtask

  task automatic check_direct(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  initial begin
    // Reset with all pins pulled high from outside
    repeat (3) @(posedge clk);
    #1;
    check_direct("reset_readdata", readdata, 32'h0);
    check_direct("reset_irq", 32'(irq), 32'h0);
    check_direct("reset_pins_released", 32'(pins), 32'hF);
    @(negedge clk); reset_n = 1'b1;
    tick();
    idle(6);
    rd(3'd3);

    // Drive all pins, load data, set and clear bits
    wr(3'd1, 32'hF);
    wr(3'd0, 32'hFFFF_FFFA);
    idle(S + 1);
    rd(3'd0);
    wr(3'd4, 32'h1);
    wr(3'd5, 32'h8);
    rd(3'd4);
    rd(3'd5);
    rd(3'd6);
    rd(3'd7);
    idle(S + 1);
    rd(3'd0);
    rd(3'd1);

    // External rising edge on pin1 with it unmasked
    ext_val = 4'h0;
    wr(3'd1, 32'h0);
    idle(S + 3);
    wr(3'd3, 32'hF);
    wr(3'd2, 32'h2);
    idle(2);
    ext_val[1] = 1'b1;
    idle(S + 4);
    rd(3'd3);
    wr(3'd3, 32'h2);
    idle(3);
    rd(3'd3);

    // Pending bit kept while masked
    ext_val[1] = 1'b0;
    idle(S + 3);
    wr(3'd2, 32'h0);
    idle(2);
    rd(3'd3);
    wr(3'd2, 32'h2);
    idle(2);
    wr(3'd3, 32'hF);
    idle(2);

    // Pin0 edge lands in the same cycle as its clear
    ext_val[0] = ~ext_val[0];
    tick();
    tick();
    wr(3'd3, 32'h1);
    rd(3'd3);
    idle(2);

    // Randomised traffic
    for (int it = 0; it < 400; it++) begin
      automatic int op = $urandom_range(0, 3);
      automatic logic [2:0] a = 3'($urandom_range(0, 7));
      case (op)
        0: wr(a, $urandom);
        1: rd(a);
        2: begin ext_val = ext_val ^ W'($urandom); tick(); end
        default: idle($urandom_range(1, 3));
      endcase
    end

    // Asynchronous reset while driving
    wr(3'd1, 32'hF);
    wr(3'd0, 32'hA);
    wr(3'd2, 32'hF);
    ext_val = 4'h5;
    idle(2);
    #2 reset_n = 1'b0;
    #1;
    check_direct("async_pins_released", 32'(pins), 32'h5);
    check_direct("async_readdata", readdata, 32'h0);
    check_direct("async_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();
    rd(3'd0);
    rd(3'd1);
    rd(3'd2);
    rd(3'd3);
    idle(S + 4);
    rd(3'd3);
    rd(3'd0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sd_bidir_pio.md
Name: sd_bidir_pio

Overview:
- Parametrised successor to the single-bit SD-card bidirectional PIO (CMD/DAT lines) on the Nios Avalon-MM fabric.
- Drives WIDTH independent tri-state pins, each with its own direction bit.
- Adds input synchronisation, atomic set/clear of outputs, per-bit edge capture and a maskable interrupt.
- Sits between the Avalon slave port and the SD connector; one instance serves CMD (WIDTH=1) or DAT[3:0] (WIDTH=4).

Parameters:
- WIDTH, 4, number of bidirectional pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (2..4).
- EDGE_TYPE, 2, capture mode: 0 rising, 1 falling, 2 any edge.
- RESET_OUT, 0, reset value of the output data register (WIDTH bits).

Ports:
- clk, in, 1, system clock; all logic is single-domain.
- reset_n, in, 1, asynchronous active-low reset.
- address, in, 3, Avalon word address.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write strobe.
- writedata, in, 32, write data; bits above WIDTH are ignored.
- readdata, out, 32, registered read data; bits above WIDTH read 0.
- irq, out, 1, level interrupt, active high.
- bidir_port, inout, WIDTH, pins; bit i is driven when dir[i]=1, else Z.

Behaviour:
- Reset values (asynchronous, on reset_n=0):
  - readdata=0, data_out=RESET_OUT, dir=0 (all pins Z), irq_mask=0, edge_capture=0, irq=0.
  - Sync chain and prev register = 0; warm-up counter = 0.
- Register map (wr = chipselect & ~write_n):
  - 0 DATA: read returns synced pin values for all bits, including bits being driven. Write loads data_out.
  - 1 DIR: read/write dir.
  - 2 IRQMASK: read/write irq_mask.
  - 3 EDGECAP: read edge_capture. Write-1-to-clear per bit.
  - 4 OUTSET: write ORs writedata into data_out. Reads 0.
  - 5 OUTCLR: write ANDs ~writedata into data_out. Reads 0.
  - 6, 7: reads 0, writes ignored.
- Read latency:
  - readdata updates every clk from the address mux, regardless of chipselect.
  - Value is valid one cycle after address is presented, with no wait states.
- Register writes take effect on the next clk edge. The pin reflects the new value immediately after that edge (combinational tri-state).
- Input path:
  - bidir_port passes through a SYNC_STAGES flop chain to give sync_in.
  - prev <= sync_in every cycle.
  - Edge vector by EDGE_TYPE: 0 gives sync_in & ~prev; 1 gives ~sync_in & prev; 2 gives sync_in ^ prev.
- Warm-up:
  - A counter of width clog2(SYNC_STAGES+2) counts from reset to SYNC_STAGES+1, then saturates.
  - Edge capture is disabled until the counter saturates. This prevents false edges on pins that are high at reset.
- Edge capture:
  - edge_capture[i] sets on a detected edge.
  - It clears only through a 1 written to EDGECAP.
  - If set and clear hit the same bit in the same cycle, set wins (bit = 1).
- Interrupt: irq <= |(edge_capture & irq_mask), registered, so it follows the contributing state by one cycle.
  - Masking a pending bit drops irq on the next cycle.
  - Pending capture bits are kept while masked.
- Driven pins: edges also capture, so software can detect its own toggles. No self-masking.
- Reset mid-operation: all state returns to reset values asynchronously and pins go Z at once. Warm-up restarts after reset_n deasserts.

Decomposition:
- Shared package sd_pio_pkg holds:
  - Address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3, ADDR_OUTSET=4, ADDR_OUTCLR=5.
  - Edge mode constants EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
- Sub-module sd_pio_sync: a WIDTH-wide, SYNC_STAGES-deep synchroniser with asynchronous active-low reset to 0, instantiated once.

Test Plan:
- Reset with pins pulled high, WIDTH=4 → bidir_port=ZZZZ, readdata=0, irq=0. EDGECAP reads 0 after warm-up, with no false edge.
- Write DIR=0xF, then DATA=0xA → pins=1010 one cycle after the write. Read DATA → 0xA after SYNC_STAGES+1 cycles.
- OUTSET 0x1, then OUTCLR 0x8, starting from DATA=0xA → data_out=0xB, then 0x3. Pins follow and reads of 4/5 return 0.
- EDGE_TYPE=0, DIR=0, IRQMASK=0x2; external pin1 driven 0→1 → EDGECAP=0x2, and irq=1 at (SYNC_STAGES+2) cycles after the pin change.
  - Write EDGECAP=0x2 → irq=0 one cycle after the capture clears.
- EDGE_TYPE=2; pin0 toggles in the same cycle that EDGECAP=0x1 is written → bit0 stays 1 (set wins).
- Assert reset_n=0 mid-drive with DIR=0xF → pins go Z asynchronously, and all registers read their reset values after release.
